// File: rtl/dmem_responder.sv
// Single-port data memory responder with a fixed-latency valid/ready response path.
// Optional error checking is enabled with `define DMEM_RESPONDER_ERR_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  // state | meaning
  // IDLE  | ready for a request
  // BUSY  | latency counter running
  // RESP  | response held until rsp_ready_i
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic [1:0]    size_eff;
  logic [1:0]    lane;
  logic [AW-1:0] idx;
  logic          req_err;
  logic [31:0]   wmask, wlane, rword, rsh_b, rsh_h, ld_data;

  assign req_ready_o = (state_q == IDLE) && !rst;
  assign accept      = req_valid_i && req_ready_o;

`ifdef DMEM_RESPONDER_ERR_EN
  always_comb begin
    size_eff = req_size_i;
    lane     = req_addr_i[1:0];
    idx      = req_addr_i[AW+1:2];
    req_err  = 1'b0;
    case (req_size_i)
      2'b01:   req_err = req_addr_i[0];
      2'b10:   req_err = |req_addr_i[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if ({2'b00, req_addr_i[31:2]} >= 32'(DEPTH_WORDS)) req_err = 1'b1;
  end
`else
  // Misaligned offsets are dropped, size 11 acts as word, index wraps.
  always_comb begin
    size_eff = (req_size_i == 2'b11) ? 2'b10 : req_size_i;
    case (size_eff)
      2'b00:   lane = req_addr_i[1:0];
      2'b01:   lane = {req_addr_i[1], 1'b0};
      default: lane = 2'b00;
    endcase
    idx     = AW'(req_addr_i[31:2] % 30'(DEPTH_WORDS));
    req_err = 1'b0;
  end
`endif

  always_comb begin
    rword = mem[idx];
    rsh_b = rword >> {lane, 3'b000};
    rsh_h = rword >> {lane[1], 4'b0000};
    case (size_eff)
      2'b00: begin
        wmask   = 32'h0000_00FF << {lane, 3'b000};
        wlane   = {24'b0, req_wdata_i[7:0]} << {lane, 3'b000};
        ld_data = {24'b0, rsh_b[7:0]};
      end
      2'b01: begin
        wmask   = 32'h0000_FFFF << {lane[1], 4'b0000};
        wlane   = {16'b0, req_wdata_i[15:0]} << {lane[1], 4'b0000};
        ld_data = {16'b0, rsh_h[15:0]};
      end
      default: begin
        wmask   = 32'hFFFF_FFFF;
        wlane   = req_wdata_i;
        ld_data = rword;
      end
    endcase
  end

  // Storage has no reset so that contents survive rst.
  always_ff @(posedge clk) begin
    if (accept && req_write_i && !req_err)
      mem[idx] <= (mem[idx] & ~wmask) | (wlane & wmask);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : BUSY;
          err_d   = req_err;
          rdata_d = (req_err || req_write_i) ? 32'b0 : ld_data;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid_o = (state_q == RESP) && !rst;
  assign rsp_rdata_o = rst ? 32'b0 : rdata_q;
  assign rsp_error_o = err_q && !rst;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in storage.
REQ-002 Parameter LATENCY, default 2: cycles from request acceptance to rsp_valid; legal range 1..15.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_size  input  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-010 req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator accepts the response.
REQ-013 rsp_rdata  output  32  load data, right-justified and zero-filled above the access size; 0 for stores.
REQ-014 rsp_error  output  1  request was rejected; no storage change occurred.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, BUSY and RESP. At most one request is outstanding.
REQ-016 req_ready SHALL be 1 only in IDLE with rst low. A request is accepted on an edge where req_valid && req_ready.
REQ-017 On acceptance, the FSM SHALL load the latency counter with LATENCY-1. It SHALL go to RESP if LATENCY==1, else to BUSY.
REQ-018 In BUSY, the counter SHALL decrement each cycle. The FSM SHALL go to RESP on the edge where the counter is 0. rsp_valid therefore rises exactly LATENCY cycles after the acceptance edge.
REQ-019 In RESP, rsp_valid, rsp_rdata and rsp_error SHALL hold stable until rsp_valid && rsp_ready. On that edge the FSM SHALL return to IDLE and rsp_valid SHALL fall.
REQ-020 No same-cycle turnaround: req_ready SHALL be 0 in the cycle that the response handshake completes.
REQ-021 Loads SHALL sample storage at the acceptance edge. The selected byte or half SHALL be chosen by addr[1:0] (byte) or addr[1] (half).
REQ-022 Stores SHALL commit at the acceptance edge.
  - Byte lane selected by addr[1:0]; half lanes selected by addr[1].
  - Unselected lanes are unchanged.
REQ-023 Word index SHALL be addr[31:2].
REQ-024 A request is an error if any of the following holds:
  - size 01 with addr[0]=1;
  - size 10 with addr[1:0]!=0;
  - size 11;
  - word index >= DEPTH_WORDS.
REQ-025 An error request SHALL NOT write storage. It SHALL complete with normal latency, rsp_error=1 and rsp_rdata=0.
REQ-026 A load from a word index, accepted the cycle after a store to that index was accepted, SHALL return the stored data.
REQ-027 req_* inputs SHALL be ignored when req_ready=0.

Reset
REQ-028 While rst is high, the following SHALL hold:
  - state=IDLE, counter=0;
  - rsp_valid=0, rsp_rdata=0, rsp_error=0;
  - req_ready=0.
REQ-029 Storage contents SHALL NOT be cleared by reset.
REQ-030 Reset during BUSY or RESP SHALL discard the pending response. A store committed before reset remains in storage.
REQ-031 req_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-032 Macro DMEM_RESPONDER_ERR_EN controls error checking.
REQ-033 With DMEM_RESPONDER_ERR_EN defined, REQ-024/REQ-025 apply.
REQ-034 Without DMEM_RESPONDER_ERR_EN:
  - rsp_error SHALL be tied 0;
  - address bits below the access size SHALL be ignored (forced aligned);
  - word index SHALL wrap modulo DEPTH_WORDS;
  - size 11 SHALL be treated as word.

Verification
REQ-035 LATENCY=2, rsp_ready=1: store word 0xDEADBEEF at 0x10, then load word 0x10 -> each rsp_valid rises 2 cycles after acceptance; load rdata=0xDEADBEEF, rsp_error=0.
REQ-036 Store byte 0xAB at 0x11 over word 0x11223344, then load word 0x10 -> 0x1122AB44. Load half 0x12 -> 0x00001122.
REQ-037 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_error stay stable and req_ready stays 0. rsp_ready=1 -> rsp_valid falls next cycle and req_ready=1 the cycle after handshake.
REQ-038 ERR_EN defined: store half at 0x13, then load word at DEPTH_WORDS*4 -> both complete with rsp_error=1, rdata=0, and the word at 0x10 is unchanged. Without ERR_EN, the same store writes lanes [31:16] of word 0x10.
REQ-039 Assert rst in the BUSY cycle after accepting a load -> rsp_valid never rises for it, and req_ready=1 the cycle after rst falls. A store accepted before reset is readable afterwards.
REQ-040 LATENCY=1, back-to-back requests with rsp_ready=1 -> one request accepted per 2 cycles with no lost or duplicated responses.
